// File: rtl/gsplat_tile_prefetch.sv
// gsplat_tile_prefetch
// Walks the per-frame tile-descriptor linked list in DDR3 and queues each
// decoded 2-qword header in a small first-word-fall-through FIFO. This lets
// the dispatch stage pop one header per tile without waiting on a DDR read.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start, first_addr   one-cycle pulse that starts a walk at first_addr (0 = empty list)
//   rd_*                read-only requestor port toward arbiter requestor 0
//   hdr_*               FWFT header FIFO head (pop on hdr_valid & hdr_ready)
//   walk_done           level, walk finished
//   overflow            walk cut short by the MAX_TILES loop guard
//   tile_count          headers read in the current walk
module gsplat_tile_prefetch #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_TILES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [28:0] first_addr,
    output logic [28:0] rd_addr,
    output logic [7:0]  rd_burstcnt,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [63:0] rd_data,
    input  logic        rd_data_valid,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [28:0] hdr_tile_addr,
    output logic [15:0] hdr_px,
    output logic [15:0] hdr_py,
    output logic [31:0] hdr_splat_count,
    output logic        hdr_last,
    output logic        walk_done,
    output logic        overflow,
    output logic [15:0] tile_count
);

    localparam int unsigned AW    = 29;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [AW-1:0] tile_addr;
        logic [15:0]   px;
        logic [15:0]   py;
        logic [31:0]   splat_count;
        logic          last;
    } hdr_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_BEAT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      cur_addr_q, cur_addr_d;
    logic [AW-1:0]      next_addr_q, next_addr_d;
    logic               rd_req_q, rd_req_d;
    logic [AW-1:0]      rd_addr_q, rd_addr_d;
    logic               walk_done_q, walk_done_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        tile_count_q, tile_count_d;

    hdr_t               mem_q [DEPTH];
    hdr_t               mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    hdr_t               head_q, head_d;
    logic               hdr_valid_q, hdr_valid_d;

    logic               push;
    logic               pop;
    hdr_t               push_entry;
    logic [15:0]        tc_inc;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_addr_q   <= '0;
            next_addr_q  <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            walk_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            tile_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_q       <= '0;
            hdr_valid_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            next_addr_q  <= next_addr_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            walk_done_q  <= walk_done_d;
            overflow_q   <= overflow_d;
            tile_count_q <= tile_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_q       <= head_d;
            hdr_valid_q  <= hdr_valid_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Walk FSM: next state, header decode and FIFO push request
    always_comb begin
        state_d      = state_q;
        cur_addr_d   = cur_addr_q;
        next_addr_d  = next_addr_q;
        walk_done_d  = walk_done_q;
        overflow_d   = overflow_q;
        tile_count_d = tile_count_q;
        push         = 1'b0;
        push_entry   = '0;
        tc_inc       = (tile_count_q == 16'hFFFF) ? tile_count_q : tile_count_q + 16'd1;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    tile_count_d = '0;
                    overflow_d   = 1'b0;
                    if (first_addr != '0) begin
                        cur_addr_d  = first_addr;
                        walk_done_d = 1'b0;
                        state_d     = S_REQ;
                    end else begin
                        walk_done_d = 1'b1;
                        state_d     = S_DONE;
                    end
                end
            end
            S_REQ: begin
                if (rd_req_q && rd_ack) begin
                    state_d = S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (rd_data_valid) begin
                    next_addr_d = rd_data[60:32];
                    state_d     = S_BEAT1;
                end
            end
            S_BEAT1: begin
                if (rd_data_valid) begin
                    push                   = 1'b1;
                    push_entry.tile_addr   = cur_addr_q;
                    push_entry.px          = rd_data[47:32];
                    push_entry.py          = rd_data[63:48];
                    push_entry.splat_count = rd_data[31:0];
                    tile_count_d           = tc_inc;
                    if (next_addr_q == '0) begin
                        push_entry.last = 1'b1;
                        walk_done_d     = 1'b1;
                        state_d         = S_DONE;
                    end else if ({16'd0, tc_inc} == 32'(MAX_TILES)) begin
                        // Loop guard: a corrupt or cyclic list must not walk forever
                        push_entry.last = 1'b1;
                        overflow_d      = 1'b1;
                        walk_done_d     = 1'b1;
                        state_d         = S_DONE;
                    end else begin
                        cur_addr_d = next_addr_q;
                        state_d    = S_REQ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Header FIFO plus registered FWFT head and read-request outputs
    always_comb begin
        pop      = hdr_valid_q & hdr_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d      = mem_d[rd_ptr_d];
        hdr_valid_d = (count_d != '0);

        // One read in flight at most, so requesting only with a free slot
        // guarantees the eventual push never lands on a full FIFO.
        rd_req_d  = (state_d == S_REQ) && (count_d < CNT_W'(DEPTH));
        rd_addr_d = cur_addr_d;
    end

    assign rd_req          = rd_req_q;
    assign rd_addr         = rd_addr_q;
    assign rd_burstcnt     = 8'd2;
    assign hdr_valid       = hdr_valid_q;
    assign hdr_tile_addr   = head_q.tile_addr;
    assign hdr_px          = head_q.px;
    assign hdr_py          = head_q.py;
    assign hdr_splat_count = head_q.splat_count;
    assign hdr_last        = head_q.last;
    assign walk_done       = walk_done_q;
    assign overflow        = overflow_q;
    assign tile_count      = tile_count_q;

endmodule
